uart_rx_8n1_sink: RTL

// - Synthesizable UART receiver for the chip's uart_tx pin, oversampled from the system clock.
// - Deserialises 8N1 frames and buffers the bytes in a small FIFO with a valid/ready drain port.
// - Counterpart to the bench-side UART transmit path (send_char).
// - Sits in the bench/FPGA harness as the console sink, replacing the behavioural uart_bus receive path.

---
 rtl/uart_rx_8n1_sink.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_8n1_sink.sv
// UART console sink: 8N1 deserialiser (even parity under `UART_RX_PARITY_EN`) into a byte FIFO.
// Latency: the byte is written on the stop-sample edge, and rx_valid_o follows on the next clock.
// Backpressure: the FIFO absorbs up to FIFO_DEPTH bytes; a further byte is dropped and raises sticky overrun_o.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] last_dat;
  logic         empty, full, push, pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_vld  = !empty;
  assign push_rdy = !full || pop_rdy;
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;
  // While empty, keep presenting the byte that was popped last.
  assign pop_dat  = empty ? last_dat : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_dat <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_dat <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

module uart_rx_8n1_sink #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 3_125_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  output logic       busy_o
);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);

  if (CPB * BAUD_RATE != CLK_FREQ_HZ || CPB < 8) begin : g_bad_baud
    $error("uart_rx_8n1_sink: CLK_FREQ_HZ/BAUD_RATE must be an integer >= 8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_8n1_sink: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            rx_s, bit_end, par_ok, push_vld, push_rdy;

  assign rx_s    = sync_q[1];
  assign bit_end = (cnt == CW'(CPB - 1));
  assign busy_o  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~(^shreg ^ par_bit);
`else
  assign par_ok       = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  assign push_vld = (state == STOP) && bit_end && rx_s && par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      case (state)
        IDLE: if (!rx_s) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == CW'(CPB / 2 - 1)) begin
          if (rx_s) state <= IDLE;
          else begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
          end
        end else cnt <= cnt + 1'b1;
        DATA: if (bit_end) begin
          cnt   <= '0;
          shreg <= {rx_s, shreg[7:1]};
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else idx <= idx + 1'b1;
        end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_end) begin
          cnt     <= '0;
          par_bit <= rx_s;
          state   <= STOP;
        end else cnt <= cnt + 1'b1;
`endif
        // Return to IDLE at the stop-bit centre so a following start edge is caught.
        STOP: if (bit_end) begin
          frame_err_o <= !rx_s;
`ifdef UART_RX_PARITY_EN
          parity_err_o <= !par_ok;
`endif
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overrun_o <= 1'b0;
    else if (push_vld && !push_rdy) overrun_o <= 1'b1;
  end

  fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (shreg),
    .push_rdy (push_rdy),
    .pop_vld  (rx_valid_o),
    .pop_rdy  (rx_ready_i),
    .pop_dat  (rx_data_o)
  );
endmodule
